// File: rtl/dip_rgb2gray_pipe.sv
// RGB565/RGB888 to 8-bit gray in a 4-stage pipeline, with optional binarisation and a frame pixel counter.
// Defining DIP_YCBCR_EN adds the dout_cb/dout_cr chroma outputs; the gray path is unchanged either way.
module dip_rgb2gray_pipe #(
  parameter int IN_FMT   = 0,
  parameter int COEF_SEL = 0,
  parameter int CNT_W    = 20
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             din_vld,
  input  logic [23:0]      din,
  input  logic             din_vsync,
  input  logic             din_href,
  input  logic             thresh_en,
  input  logic [7:0]       thresh,
  output logic             dout_vld,
  output logic [7:0]       dout_gray,
  output logic [15:0]      dout_rgb565,
  output logic             dout_vsync,
  output logic             dout_href,
  output logic [CNT_W-1:0] frame_pix
`ifdef DIP_YCBCR_EN
  ,
  output logic [7:0]       dout_cb,
  output logic [7:0]       dout_cr
`endif
);
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam logic [COEF_W-1:0] K_R = (COEF_SEL == 1) ? 8'd54  : 8'd77;
  localparam logic [COEF_W-1:0] K_G = (COEF_SEL == 1) ? 8'd183 : 8'd150;
  localparam logic [COEF_W-1:0] K_B = (COEF_SEL == 1) ? 8'd19  : 8'd29;

  // Rounding bias is already in the sum; the saturation branch can never fire with these coefficients.
  function automatic logic [DATA_W-1:0] round_sat(input logic [16:0] sum);
    logic [16:0] sh;
    sh = sum >> 8;
    round_sat = (sh > 17'd255) ? 8'hFF : sh[7:0];
  endfunction

  function automatic logic [DATA_W-1:0] binarise(input logic [DATA_W-1:0] y, input logic en,
                                                 input logic [DATA_W-1:0] th);
    if (en) binarise = (y >= th) ? 8'hFF : 8'h00;
    else    binarise = y;
  endfunction

  function automatic logic [15:0] pack565(input logic [DATA_W-1:0] y);
    pack565 = {y[7:3], y[7:2], y[7:3]};
  endfunction

  logic [DATA_W-1:0] r_in, g_in, b_in;

  always_comb begin
    if (IN_FMT == 1) begin
      r_in = din[23:16];
      g_in = din[15:8];
      b_in = din[7:0];
    end else begin
      r_in = {din[15:11], din[15:13]};
      g_in = {din[10:5], din[10:9]};
      b_in = {din[4:0], din[4:2]};
    end
  end

  logic                     vld_p1, vs_p1, hr_p1, te_p1;
  logic [DATA_W-1:0]        r_p1, g_p1, b_p1, th_p1;
  logic                     vld_p2, vs_p2, hr_p2, te_p2;
  logic [DATA_W-1:0]        th_p2;
  logic [2*DATA_W-1:0]      pr_p2, pg_p2, pb_p2;
  logic                     vld_p3, vs_p3, hr_p3, te_p3;
  logic [DATA_W-1:0]        th_p3;
  logic [2*DATA_W:0]        sum_p3;
  logic [DATA_W-1:0]        y_p3;

  assign y_p3 = binarise(round_sat(sum_p3), te_p3, th_p3);

  always_ff @(posedge pclk) begin
    if (rst) begin
      {vld_p1, vs_p1, hr_p1, te_p1} <= '0;
      {vld_p2, vs_p2, hr_p2, te_p2} <= '0;
      {vld_p3, vs_p3, hr_p3, te_p3} <= '0;
      {dout_vld, dout_vsync, dout_href} <= '0;
      r_p1 <= '0; g_p1 <= '0; b_p1 <= '0; th_p1 <= '0;
      pr_p2 <= '0; pg_p2 <= '0; pb_p2 <= '0; th_p2 <= '0;
      sum_p3 <= '0; th_p3 <= '0;
      dout_gray <= '0; dout_rgb565 <= '0;
    end else begin
      // S1: capture pixel and its threshold settings
      {vld_p1, vs_p1, hr_p1} <= {din_vld, din_vsync, din_href};
      if (din_vld) begin
        r_p1 <= r_in; g_p1 <= g_in; b_p1 <= b_in;
        te_p1 <= thresh_en; th_p1 <= thresh;
      end
      // S2: weighted channels
      {vld_p2, vs_p2, hr_p2} <= {vld_p1, vs_p1, hr_p1};
      if (vld_p1) begin
        pr_p2 <= 16'(r_p1) * 16'(K_R);
        pg_p2 <= 16'(g_p1) * 16'(K_G);
        pb_p2 <= 16'(b_p1) * 16'(K_B);
        te_p2 <= te_p1; th_p2 <= th_p1;
      end
      // S3: sum with rounding bias
      {vld_p3, vs_p3, hr_p3} <= {vld_p2, vs_p2, hr_p2};
      if (vld_p2) begin
        sum_p3 <= 17'(pr_p2) + 17'(pg_p2) + 17'(pb_p2) + 17'd128;
        te_p3 <= te_p2; th_p3 <= th_p2;
      end
      // S4: luma / binary output, held across bubbles
      {dout_vld, dout_vsync, dout_href} <= {vld_p3, vs_p3, hr_p3};
      if (vld_p3) begin
        dout_gray   <= y_p3;
        dout_rgb565 <= pack565(y_p3);
      end
    end
  end

  logic             vs_q;
  logic [CNT_W-1:0] cnt;

  // A pixel arriving with the vsync rising edge is the first pixel of the new frame.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_q <= 1'b0;
      cnt <= '0;
      frame_pix <= '0;
    end else begin
      vs_q <= din_vsync;
      if (din_vsync && !vs_q) begin
        frame_pix <= cnt;
        cnt <= din_vld ? CNT_W'(1) : '0;
      end else if (din_vld && cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef DIP_YCBCR_EN
  localparam logic signed [8:0] CB_R = (COEF_SEL == 1) ? -9'sd29  : -9'sd43;
  localparam logic signed [8:0] CB_G = (COEF_SEL == 1) ? -9'sd99  : -9'sd85;
  localparam logic signed [8:0] CB_B = 9'sd128;
  localparam logic signed [8:0] CR_R = 9'sd128;
  localparam logic signed [8:0] CR_G = (COEF_SEL == 1) ? -9'sd116 : -9'sd107;
  localparam logic signed [8:0] CR_B = (COEF_SEL == 1) ? -9'sd12  : -9'sd21;

  function automatic logic [DATA_W-1:0] clamp_u8(input logic signed [18:0] sum);
    logic signed [18:0] t;
    t = (sum >>> 8) + 19'sd128;
    if (t < 19'sd0)        clamp_u8 = 8'h00;
    else if (t > 19'sd255) clamp_u8 = 8'hFF;
    else                   clamp_u8 = t[7:0];
  endfunction

  logic signed [17:0] cbr_p2, cbg_p2, cbb_p2, crr_p2, crg_p2, crb_p2;
  logic signed [18:0] cb_p3, cr_p3;

  always_ff @(posedge pclk) begin
    if (rst) begin
      cbr_p2 <= '0; cbg_p2 <= '0; cbb_p2 <= '0;
      crr_p2 <= '0; crg_p2 <= '0; crb_p2 <= '0;
      cb_p3 <= '0; cr_p3 <= '0;
      dout_cb <= '0; dout_cr <= '0;
    end else begin
      // S2: signed chroma products
      if (vld_p1) begin
        cbr_p2 <= 18'($signed({1'b0, r_p1})) * 18'(CB_R);
        cbg_p2 <= 18'($signed({1'b0, g_p1})) * 18'(CB_G);
        cbb_p2 <= 18'($signed({1'b0, b_p1})) * 18'(CB_B);
        crr_p2 <= 18'($signed({1'b0, r_p1})) * 18'(CR_R);
        crg_p2 <= 18'($signed({1'b0, g_p1})) * 18'(CR_G);
        crb_p2 <= 18'($signed({1'b0, b_p1})) * 18'(CR_B);
      end
      // S3: chroma sums with rounding bias
      if (vld_p2) begin
        cb_p3 <= 19'(cbr_p2) + 19'(cbg_p2) + 19'(cbb_p2) + 19'sd128;
        cr_p3 <= 19'(crr_p2) + 19'(crg_p2) + 19'(crb_p2) + 19'sd128;
      end
      // S4: offset and clamp
      if (vld_p3) begin
        dout_cb <= clamp_u8(cb_p3);
        dout_cr <= clamp_u8(cr_p3);
      end
    end
  end
`endif

endmodule
